clkdiv_bank: RTL and testbench
==============================

# clkdiv_bank

Multi-channel programmable clock-enable generator for the arm controller. It runs N independent divider channels from the single 50 MHz system clock. Each channel produces a one-cycle `tick` strobe and a registered square wave `clk_div`. Divisors are reprogrammable at run time through a valid/ready config port, and a new divisor takes effect glitch-free at the next period boundary. Downstream logic (accelerometer sampling, servo PWM, display scan) consumes `tick` as a clock enable instead of using divided clocks.

## Interface
- `CLK_FREQ`, default 50_000_000: system clock frequency in Hz.
- `CHANNELS`, default 4: number of divider channels, 1..16.
- `CNT_W`, default 32: counter and divisor width.
- `DEFAULT_FREQ`, default 2: reset output frequency of every channel. Reset divisor = `CLK_FREQ/DEFAULT_FREQ`, which must fit `CNT_W` and be ≥2.
- `clk  in  1`: system clock. This is the only clock.
- `rst  in  1`: asynchronous, active-low reset.
- `en  in  CHANNELS`: per-channel run enable, synchronous.
- `cfg_valid  in  1`: config write request.
- `cfg_ready  out  1`: config write can be accepted.
- `cfg_chan  in  CH_W`: target channel. `CH_W = max(1, clog2(CHANNELS))`.
- `cfg_div  in  CNT_W`: new divisor P, in clock cycles per output period.
- `tick  out  CHANNELS`: one-cycle strobe, once per period.
- `clk_div  out  CHANNELS`: square wave with period P.
- `cfg_pend  out  CHANNELS`: channel has an accepted divisor not yet applied.

## Operation
- Per-channel state:
  - active divisor `P`: reset value is the default divisor.
  - counter `cnt`: range 0..P-1, reset value 0.
  - pending divisor and pending flag: reset value 0.
- Enabled channel, at each clock edge:
  - If `cnt==P-1`: `cnt`←0, `tick`←1, `clk_div`←1. If the pending flag is set, `P`←pending and the flag is cleared.
  - Else if `cnt==(P>>1)-1`: `cnt`++, `tick`←0, `clk_div`←0.
  - Otherwise: `cnt`++, `tick`←0, `clk_div` holds.
- Resulting waveform: `clk_div` is high for `P>>1` cycles, starting with the tick cycle, and low for `P-(P>>1)` cycles. For odd P the low phase is one cycle longer.
- Disabled channel (`en=0`):
  - `cnt` is held at 0, and `tick` and `clk_div` are 0 on the next edge.
  - A pending divisor is applied on the next edge.
- Config write:
  - `cfg_ready = ~cfg_pend[cfg_chan]`, combinational.
  - A write is accepted on an edge where `cfg_valid & cfg_ready`. That edge sets the channel's pending divisor and flag.
  - `cfg_div < 2` is clamped to 2.
  - `cfg_chan ≥ CHANNELS` is accepted and dropped, with no effect.
- A write accepted on the same edge as the channel's wrap is not applied at that wrap. It is applied at the following wrap.
- While `cfg_pend` is set, further writes to that channel stall (`cfg_ready=0`). Writes to other channels proceed.
- Reset asserted mid-operation: all counters and flags clear immediately. P returns to the default divisor. Pending writes are discarded.

## Timing
- Reset values: `tick=0`, `clk_div=0`, `cfg_pend=0`, and `cfg_ready=1` for every valid `cfg_chan`.
- After `en` rises, the first `tick` is high in the cycle following the P-th enabled edge. Ticks then repeat every P cycles exactly.
- `cfg_pend` rises in the cycle after acceptance.
  - Enabled channel: `cfg_pend` falls in the cycle after the applying wrap, which is within P_old cycles.
  - Disabled channel: `cfg_pend` falls 1 cycle after it rose.
- The period containing the switch keeps the old P. The new P applies to the period that starts at the tick.
- All outputs except `cfg_ready` are registered.

## Structure
- `clkdiv_pkg` holds:
  - `MIN_DIV = 2`;
  - the `CH_W` computation function;
  - the default-divisor calculation helper.
- Sub-module `clkdiv_chan`: one channel, containing the counter, active/pending divisor, tick/clk_div logic and pending handshake. It is instantiated `CHANNELS` times by a generate loop.
- The top level contains only the config decode and `cfg_ready` mux.

## Test plan
All scenarios use `CLK_FREQ=100`, `DEFAULT_FREQ=10` (reset P=10) and `CHANNELS=4`.
- Reset, then `en=4'b0001` for 40 cycles → `tick[0]` at cycles 10, 20, 30, 40. `clk_div[0]` is high 5 cycles and low 5 cycles. Channels 1-3 stay 0.
- Write P=3 to ch1 while ch1 is disabled, then enable ch1 → `cfg_pend[1]` is high for 1 cycle. Ticks every 3 cycles, with `clk_div` high 1 and low 2.
- Ch0 running at P=10: write P=4 at `cnt=3` → `cfg_pend[0]` stays high until the next wrap. The next tick is 10 cycles after the previous one, then every 4.
- Write P=6 to ch0 while it is pending, with `cfg_valid` held → `cfg_ready=0` until the wrap, then the write is accepted. Meanwhile a write to ch2 is accepted immediately.
- Write `cfg_div=0` and `cfg_div=1` → channel runs at P=2, alternating tick, with `clk_div` toggling every cycle.
- Assert `rst` mid-period with a write pending on ch3 → all outputs are 0 and `cfg_pend=0`. After release, ch3 ticks at P=10, not at the discarded value.

Source files
------------

// File: rtl/clkdiv_pkg.sv
// clkdiv_pkg
// Shared constants and elaboration-time helpers for the clock-enable
// divider bank.
//   MIN_DIV      smallest divisor a channel will run at
//   ch_width()   width of the channel-select field
//   default_div  divisor loaded at reset
package clkdiv_pkg;

  localparam int MIN_DIV = 2;

  // A single-channel bank still gets a 1-bit select so the port never
  // collapses to zero width.
  function automatic int ch_width(input int channels);
    return (channels > 1) ? $clog2(channels) : 1;
  endfunction

  // Clock cycles per output period for the requested reset frequency.
  function automatic int default_div(input int clk_freq, input int freq);
    return clk_freq / freq;
  endfunction

endpackage

// File: rtl/clkdiv_chan.sv
// clkdiv_chan
// One divider channel. It holds the period counter, the active divisor and a
// one-deep pending divisor that is swapped in only at a period boundary, or
// on the next edge while the channel is disabled.
// Ports:
//   clk      system clock
//   rst      asynchronous active-low reset
//   en       run enable; while low the counter is held at 0
//   wr       accepted config write for this channel (only while pend is low)
//   wr_div   requested divisor; values below MIN_DIV are clamped
//   tick     one-cycle strobe at the start of each period
//   clk_div  square wave, high for P>>1 cycles starting with the tick cycle
//   pend     a written divisor is waiting to be applied
module clkdiv_chan
  import clkdiv_pkg::*;
#(
  parameter int               CNT_W   = 32,
  parameter logic [CNT_W-1:0] RST_DIV = CNT_W'(MIN_DIV)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             wr,
  input  logic [CNT_W-1:0] wr_div,
  output logic             tick,
  output logic             clk_div,
  output logic             pend
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] MIN = CNT_W'(MIN_DIV);

  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] div_reg;
  logic [CNT_W-1:0] pdiv_reg;
  logic             pend_reg;
  logic             tick_reg;
  logic             clk_div_reg;

  logic [CNT_W-1:0] div_clamped;
  logic             at_wrap;
  logic             at_half;
  logic             apply;

  assign div_clamped = (wr_div < MIN) ? MIN : wr_div;
  assign at_wrap     = (cnt_reg == div_reg - ONE);
  assign at_half     = (cnt_reg == (div_reg >> 1) - ONE);

  // The swap happens only at a boundary so the running period never gets
  // truncated or stretched mid-way.
  assign apply = pend_reg & (~en | at_wrap);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_reg     <= '0;
      div_reg     <= RST_DIV;
      pdiv_reg    <= '0;
      pend_reg    <= 1'b0;
      tick_reg    <= 1'b0;
      clk_div_reg <= 1'b0;
    end else begin
      if (!en) begin
        cnt_reg     <= '0;
        tick_reg    <= 1'b0;
        clk_div_reg <= 1'b0;
      end else if (at_wrap) begin
        cnt_reg     <= '0;
        tick_reg    <= 1'b1;
        clk_div_reg <= 1'b1;
      end else if (at_half) begin
        cnt_reg     <= cnt_reg + ONE;
        tick_reg    <= 1'b0;
        clk_div_reg <= 1'b0;
      end else begin
        cnt_reg  <= cnt_reg + ONE;
        tick_reg <= 1'b0;
      end

      if (apply) begin
        div_reg  <= pdiv_reg;
        pend_reg <= 1'b0;
      end

      // wr is only possible while pend_reg is low, so it never collides with
      // apply; a write landing on a wrap edge therefore waits a full period.
      if (wr) begin
        pdiv_reg <= div_clamped;
        pend_reg <= 1'b1;
      end
    end
  end

  assign tick    = tick_reg;
  assign clk_div = clk_div_reg;
  assign pend    = pend_reg;

endmodule

// File: rtl/clkdiv_bank.sv
// clkdiv_bank
// Bank of independent programmable clock-enable generators sharing one
// valid/ready config port.
// Ports:
//   clk        system clock (only clock)
//   rst        asynchronous active-low reset
//   en         per-channel run enable
//   cfg_valid  config write request
//   cfg_ready  write can be accepted (target channel has nothing pending)
//   cfg_chan   target channel; out-of-range channels accept and drop
//   cfg_div    new divisor in clock cycles per period
//   tick       per-channel one-cycle period strobe
//   clk_div    per-channel square wave
//   cfg_pend   per-channel accepted-but-not-applied flag
module clkdiv_bank
  import clkdiv_pkg::*;
#(
  parameter int  CLK_FREQ     = 50_000_000,
  parameter int  CHANNELS     = 4,
  parameter int  CNT_W        = 32,
  parameter int  DEFAULT_FREQ = 2,
  localparam int CH_W         = ch_width(CHANNELS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] en,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [CH_W-1:0]     cfg_chan,
  input  logic [CNT_W-1:0]    cfg_div,
  output logic [CHANNELS-1:0] tick,
  output logic [CHANNELS-1:0] clk_div,
  output logic [CHANNELS-1:0] cfg_pend
);

  localparam int               SEL_N   = 1 << CH_W;
  localparam logic [CNT_W-1:0] RST_DIV = CNT_W'(default_div(CLK_FREQ, DEFAULT_FREQ));

  // Zero-padded to the full select range: unused codes read as "not
  // pending", so writes to them are accepted and simply go nowhere.
  logic [SEL_N-1:0] pend_sel;
  logic             accept;

  assign pend_sel  = SEL_N'(cfg_pend);
  assign cfg_ready = ~pend_sel[cfg_chan];
  assign accept    = cfg_valid & cfg_ready;

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_chan
      logic wr;
      assign wr = accept & (cfg_chan == CH_W'(gi));

      clkdiv_chan #(
        .CNT_W   (CNT_W),
        .RST_DIV (RST_DIV)
      ) u_chan (
        .clk     (clk),
        .rst     (rst),
        .en      (en[gi]),
        .wr      (wr),
        .wr_div  (cfg_div),
        .tick    (tick[gi]),
        .clk_div (clk_div[gi]),
        .pend    (cfg_pend[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_clkdiv_bank.sv
// tb_clkdiv_bank
// Directed bench for clkdiv_bank with CLK_FREQ=100, DEFAULT_FREQ=10 (P=10),
// CHANNELS=4. Expected tick cycles are queued per channel; a monitor pops
// one entry per observed tick. Waveform, pending and ready values are
// compared against hand-computed constants.
module tb_clkdiv_bank;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  en;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [1:0]  cfg_chan;
  logic [31:0] cfg_div;
  logic [3:0]  tick;
  logic [3:0]  clk_div;
  logic [3:0]  cfg_pend;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int base   = 0;
  int mon_e;
  int exp_q[4][$];

  clkdiv_bank #(
    .CLK_FREQ     (100),
    .CHANNELS     (4),
    .CNT_W        (32),
    .DEFAULT_FREQ (10)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_chan  (cfg_chan),
    .cfg_div   (cfg_div),
    .tick      (tick),
    .clk_div   (clk_div),
    .cfg_pend  (cfg_pend)
  );

  always #5 clk = ~clk;

  // cyc == N after the N-th rising edge
  always @(posedge clk) cyc <= cyc + 1;

  // Tick monitor: every observed tick must match the head of its queue.
  always @(negedge clk) begin
    for (int c = 0; c < 4; c++) begin
      if (tick[c]) begin
        checks++;
        if (exp_q[c].size() == 0) begin
          errors++;
          $display("FAIL tick_unexpected ch%0d at cycle %0d (none required)", c, cyc - base);
        end else begin
          mon_e = exp_q[c].pop_front();
          if (mon_e != cyc) begin
            errors++;
            $display("FAIL tick_time ch%0d got cycle %0d required %0d", c, cyc - base, mon_e - base);
          end else begin
            $display("tick ch%0d cycle %0d ok", c, cyc - base);
          end
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d got %0h required %0h", nm, cyc - base, act, exp);
    end
  endtask

  task automatic wait_to(input int t);
    while (cyc < base + t) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_tick(input int c, input int t);
    exp_q[c].push_back(base + t);
  endtask

  initial begin
    rst       = 1'b0;
    en        = 4'b0000;
    cfg_valid = 1'b0;
    cfg_chan  = 2'd0;
    cfg_div   = 32'd0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_tick", tick, 4'b0000);
    chk("rst_clk_div", clk_div, 4'b0000);
    chk("rst_cfg_pend", cfg_pend, 4'b0000);
    for (int c = 0; c < 4; c++) begin
      cfg_chan = 2'(c);
      #1;
      chk("rst_cfg_ready", cfg_ready, 1'b1);
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;

    // S1: ch0 at the default P=10
    base = cyc;
    en   = 4'b0001;
    for (int t = 10; t <= 60; t += 10) push_tick(0, t);
    for (int t = 1; t <= 40; t++) begin
      wait_to(t);
      chk("s1_clk_div", clk_div,
          (t >= 10 && ((t - 10) % 10) < 5) ? 32'h1 : 32'h0);
    end

    // S2: P=3 on disabled ch1, then enable
    wait_to(41);
    cfg_valid = 1'b1; cfg_chan = 2'd1; cfg_div = 32'd3;
    #1;
    chk("s2_ready", cfg_ready, 1'b1);
    wait_to(42);
    cfg_valid = 1'b0;
    chk("s2_pend_rise", cfg_pend[1], 1'b1);
    wait_to(43);
    chk("s2_pend_fall", cfg_pend[1], 1'b0);
    wait_to(44);
    en = 4'b0011;
    push_tick(1, 47); push_tick(1, 50); push_tick(1, 53); push_tick(1, 56);
    for (int t = 45; t <= 55; t++) begin
      wait_to(t);
      chk("s2_clk_div1", clk_div[1],
          (t >= 47 && ((t - 47) % 3) == 0) ? 32'h1 : 32'h0);
    end
    wait_to(56);
    en = 4'b0001;

    // S3: P=4 on running ch0 at cnt=3; S4: P=6 stalls, ch2 goes through
    push_tick(0, 70); push_tick(0, 74); push_tick(0, 80);
    push_tick(0, 86); push_tick(0, 92);
    wait_to(63);
    cfg_valid = 1'b1; cfg_chan = 2'd0; cfg_div = 32'd4;
    #1;
    chk("s3_ready", cfg_ready, 1'b1);
    wait_to(64);
    cfg_div = 32'd6;
    chk("s3_pend_rise", cfg_pend[0], 1'b1);
    #1;
    chk("s4_ready_stall", cfg_ready, 1'b0);
    wait_to(65);
    chk("s4_ready_stall", cfg_ready, 1'b0);
    wait_to(66);
    cfg_chan = 2'd2; cfg_div = 32'd7;
    #1;
    chk("s4_ready_ch2", cfg_ready, 1'b1);
    wait_to(67);
    cfg_chan = 2'd0; cfg_div = 32'd6;
    chk("s4_pend_ch2", cfg_pend[2], 1'b1);
    #1;
    chk("s4_ready_stall", cfg_ready, 1'b0);
    wait_to(68);
    chk("s4_pend_ch2_fall", cfg_pend[2], 1'b0);
    chk("s4_ready_stall", cfg_ready, 1'b0);
    wait_to(69);
    chk("s3_pend_hold", cfg_pend[0], 1'b1);
    chk("s4_ready_stall", cfg_ready, 1'b0);
    wait_to(70);
    chk("s3_pend_fall", cfg_pend[0], 1'b0);
    chk("s4_ready_free", cfg_ready, 1'b1);
    wait_to(71);
    cfg_valid = 1'b0;
    chk("s4_pend_rise", cfg_pend[0], 1'b1);

    // S5: cfg_div=0 then cfg_div=1 both clamp to P=2 (ch1)
    wait_to(72);
    cfg_valid = 1'b1; cfg_chan = 2'd1; cfg_div = 32'd0;
    #1;
    chk("s5_ready", cfg_ready, 1'b1);
    wait_to(73);
    cfg_valid = 1'b0;
    chk("s5_pend_rise", cfg_pend[1], 1'b1);
    chk("s4_pend_hold", cfg_pend[0], 1'b1);
    wait_to(74);
    chk("s5_pend_fall", cfg_pend[1], 1'b0);
    chk("s4_pend_fall", cfg_pend[0], 1'b0);
    wait_to(75);
    en = 4'b0011;
    for (int t = 77; t <= 85; t += 2) push_tick(1, t);
    for (int t = 76; t <= 85; t++) begin
      wait_to(t);
      chk("s5_clk_div1", clk_div[1],
          (t >= 77 && ((t - 77) % 2) == 0) ? 32'h1 : 32'h0);
      if (t == 80) begin
        cfg_valid = 1'b1; cfg_chan = 2'd1; cfg_div = 32'd1;
      end
      if (t == 81) begin
        cfg_valid = 1'b0;
        chk("s5_wrap_write_pend", cfg_pend[1], 1'b1);
      end
      if (t == 82) chk("s5_wrap_write_hold", cfg_pend[1], 1'b1);
      if (t == 83) chk("s5_wrap_write_fall", cfg_pend[1], 1'b0);
    end
    wait_to(86);
    en = 4'b0001;

    // S6: reset with a write pending on ch3
    wait_to(88);
    en = 4'b1001;
    wait_to(90);
    cfg_valid = 1'b1; cfg_chan = 2'd3; cfg_div = 32'd3;
    wait_to(91);
    cfg_valid = 1'b0;
    chk("s6_pend_rise", cfg_pend[3], 1'b1);
    wait_to(93);
    chk("s6_pend_hold", cfg_pend[3], 1'b1);
    rst = 1'b0;
    #1;
    chk("s6_rst_tick", tick, 4'b0000);
    chk("s6_rst_clk_div", clk_div, 4'b0000);
    chk("s6_rst_pend", cfg_pend, 4'b0000);
    chk("s6_rst_ready", cfg_ready, 1'b1);
    wait_to(95);
    rst = 1'b1;
    push_tick(0, 105); push_tick(0, 115);
    push_tick(3, 105); push_tick(3, 115);
    for (int t = 104; t <= 111; t++) begin
      wait_to(t);
      chk("s6_clk_div3", clk_div[3],
          (t >= 105 && t < 110) ? 32'h1 : 32'h0);
    end
    wait_to(118);

    for (int c = 0; c < 4; c++) begin
      checks++;
      if (exp_q[c].size() != 0) begin
        errors++;
        $display("FAIL tick_missing ch%0d got %0d outstanding required 0", c, exp_q[c].size());
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
